// File: rtl/mem_access_unit.sv
// mem_access_unit: sequential load/store unit between the memory stage and the data bus.
// Accepts one access per handshake, drives up to two aligned bus beats, and returns
// sign/zero-extended load data with a one-cycle response pulse.
// Optional feature macro: MEM_MISALIGN_SPLIT_EN enables splitting an access that crosses
// a bus-word boundary into two beats; without it any misaligned access is rejected.
module mem_access_unit #(
   parameter int unsigned XLEN      = 64,
   parameter int unsigned BUS_BYTES = 8,
   parameter int unsigned AW        = 64
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [AW-1:0]          req_addr,
   input  logic [XLEN-1:0]        req_wdata,
   input  logic [3:0]             req_mode,
   output logic                   resp_valid,
   output logic [XLEN-1:0]        resp_rdata,
   output logic                   resp_err,
   output logic                   dbus_valid,
   output logic [AW-1:0]          dbus_addr,
   output logic [2:0]             dbus_size,
   output logic [BUS_BYTES-1:0]   dbus_strobe,
   output logic [8*BUS_BYTES-1:0] dbus_wdata,
   input  logic                   dbus_data_ok,
   input  logic [8*BUS_BYTES-1:0] dbus_rdata
);

   localparam int NumLanes    = BUS_BYTES;
   localparam int NumRegBytes = XLEN / 8;
   localparam int OffW        = $clog2(BUS_BYTES);
   localparam int RIdxW       = $clog2(XLEN / 8);
`ifdef MEM_MISALIGN_SPLIT_EN
   // Two bus words side by side so a boundary-crossing access can be laid out in one pass.
   localparam int NumWideLanes = 2 * BUS_BYTES;
`else
   localparam int NumWideLanes = BUS_BYTES;
`endif
   localparam int WIdxW = $clog2(NumWideLanes);

   typedef enum logic [1:0] {StIdle, StBeat0, StBeat1, StResp} state_e;

   state_e                           state_q, state_d;
   logic [AW-1:0]                    addr_q, addr_d;
   logic [XLEN-1:0]                  wdata_q, wdata_d;
   logic [3:0]                       mode_q, mode_d;
   logic                             err_q, err_d;
   logic [NumRegBytes-1:0][7:0]      rbytes_q, rbytes_d;

   int                               off;
   int                               nbytes;
   logic                             req_bad;
   logic [AW-1:0]                    base_addr;
   logic [NumLanes-1:0][7:0]         rd_lanes;
   logic [NumRegBytes-1:0][7:0]      wd_bytes;
   logic [NumWideLanes-1:0]          wide_strb;
   logic [NumWideLanes-1:0][7:0]     wide_wd;
   logic [NumRegBytes-1:0][7:0]      ext;
   logic                             sign;

   assign rd_lanes  = dbus_rdata;
   assign wd_bytes  = wdata_q;
   assign base_addr = {addr_q[AW-1:OffW], {OffW{1'b0}}};
   assign dbus_size = 3'(OffW);

   // Byte offset within the bus word and access size of the latched request.
   always_comb begin
      off    = int'(addr_q[OffW-1:0]);
      nbytes = 1 << mode_q[1:0];
   end

   // Classify an incoming request as illegal (no bus beat, error response).
   always_comb begin
      logic illegal;
`ifndef MEM_MISALIGN_SPLIT_EN
      int   req_n;
      logic misal;
`endif
      illegal = 1'b0;
      if (req_mode[1:0] == 2'd3 && XLEN == 32)      illegal = 1'b1;
      if (req_mode[1:0] == 2'd3 && BUS_BYTES == 4)  illegal = 1'b1;
      if (req_mode[3] && req_mode[2])               illegal = 1'b1;
      if (!req_mode[3] && req_mode[2] && req_mode[1:0] == 2'd3) illegal = 1'b1;
`ifdef MEM_MISALIGN_SPLIT_EN
      req_bad = illegal;
`else
      req_n   = 1 << req_mode[1:0];
      misal   = (req_addr[2:0] & 3'(req_n - 1)) != 3'b000;
      req_bad = illegal | misal;
`endif
   end

   // Lay the store out across (up to two) bus words: strobe bits and shifted data bytes.
   always_comb begin
      wide_strb = '0;
      wide_wd   = '0;
      for (int j = 0; j < NumRegBytes; j++) begin
         if (j < nbytes && off + j < NumWideLanes) begin
            wide_strb[WIdxW'(off + j)] = 1'b1;
            wide_wd[WIdxW'(off + j)]   = wd_bytes[RIdxW'(j)];
         end
      end
   end

   // Next-state logic: handshake, beat sequencing and load byte capture.
   always_comb begin
      int idx;
      state_d  = state_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      mode_d   = mode_q;
      err_d    = err_q;
      rbytes_d = rbytes_q;
      idx      = 0;
      case (state_q)
         StIdle: begin
            if (req_valid && req_ready) begin
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               mode_d   = req_mode;
               err_d    = req_bad;
               rbytes_d = '0;
               state_d  = req_bad ? StResp : StBeat0;
            end
         end
         StBeat0: begin
            if (dbus_data_ok) begin
               for (int i = 0; i < NumLanes; i++) begin
                  idx = i - off;
                  if (idx >= 0 && idx < nbytes && idx < NumRegBytes) begin
                     rbytes_d[RIdxW'(idx)] = rd_lanes[OffW'(i)];
                  end
               end
`ifdef MEM_MISALIGN_SPLIT_EN
               state_d = (off + nbytes > NumLanes) ? StBeat1 : StResp;
`else
               state_d = StResp;
`endif
            end
         end
`ifdef MEM_MISALIGN_SPLIT_EN
         StBeat1: begin
            if (dbus_data_ok) begin
               // Lane i of the second word holds access byte (NumLanes - off + i).
               for (int i = 0; i < NumLanes; i++) begin
                  idx = NumLanes - off + i;
                  if (idx < nbytes && idx < NumRegBytes) begin
                     rbytes_d[RIdxW'(idx)] = rd_lanes[OffW'(i)];
                  end
               end
               state_d = StResp;
            end
         end
`endif
         StResp:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // State and request registers; reset aborts any access in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         addr_q   <= '0;
         wdata_q  <= '0;
         mode_q   <= '0;
         err_q    <= 1'b0;
         rbytes_q <= '0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         mode_q   <= mode_d;
         err_q    <= err_d;
         rbytes_q <= rbytes_d;
      end
   end

   // Bus request outputs, held stable for the whole beat.
   always_comb begin
      dbus_valid  = 1'b0;
      dbus_addr   = '0;
      dbus_strobe = '0;
      dbus_wdata  = '0;
      case (state_q)
         StBeat0: begin
            dbus_valid = 1'b1;
            dbus_addr  = base_addr;
            if (mode_q[3]) begin
               dbus_strobe = wide_strb[NumLanes-1:0];
               dbus_wdata  = wide_wd[NumLanes-1:0];
            end
         end
`ifdef MEM_MISALIGN_SPLIT_EN
         StBeat1: begin
            dbus_valid = 1'b1;
            dbus_addr  = base_addr + AW'(BUS_BYTES);
            if (mode_q[3]) begin
               dbus_strobe = wide_strb[NumWideLanes-1:NumLanes];
               dbus_wdata  = wide_wd[NumWideLanes-1:NumLanes];
            end
         end
`endif
         default: ;
      endcase
   end

   // Sign/zero extension of the merged load bytes.
   always_comb begin
      ext  = '0;
      sign = 1'b0;
      if (nbytes - 1 < NumRegBytes) begin
         sign = rbytes_q[RIdxW'(nbytes - 1)][7] & ~mode_q[2];
      end
      for (int j = 0; j < NumRegBytes; j++) begin
         ext[RIdxW'(j)] = (j < nbytes) ? rbytes_q[RIdxW'(j)] : {8{sign}};
      end
   end

   // Handshake and response outputs; req_ready is gated by reset so it reads 0 while held.
   always_comb begin
      req_ready  = reset_n && (state_q == StIdle);
      resp_valid = (state_q == StResp);
      resp_err   = resp_valid && err_q;
      resp_rdata = (resp_valid && !err_q && !mode_q[3]) ? ext : '0;
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit (XLEN=64, BUS_BYTES=8, AW=64).
// Follows the build's MEM_MISALIGN_SPLIT_EN setting for boundary-crossing cases.
module tb_mem_access_unit;

   localparam int unsigned XLEN = 64;
   localparam int unsigned BB   = 8;
   localparam int unsigned AW   = 64;

   logic            clk = 1'b0;
   logic            reset_n = 1'b0;
   logic            req_valid = 1'b0;
   logic            req_ready;
   logic [AW-1:0]   req_addr = '0;
   logic [XLEN-1:0] req_wdata = '0;
   logic [3:0]      req_mode = '0;
   logic            resp_valid;
   logic [XLEN-1:0] resp_rdata;
   logic            resp_err;
   logic            dbus_valid;
   logic [AW-1:0]   dbus_addr;
   logic [2:0]      dbus_size;
   logic [BB-1:0]   dbus_strobe;
   logic [8*BB-1:0] dbus_wdata;
   logic            dbus_data_ok = 1'b0;
   logic [8*BB-1:0] dbus_rdata = '0;

   mem_access_unit #(.XLEN(XLEN), .BUS_BYTES(BB), .AW(AW)) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .req_mode     (req_mode),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .dbus_valid   (dbus_valid),
      .dbus_addr    (dbus_addr),
      .dbus_size    (dbus_size),
      .dbus_strobe  (dbus_strobe),
      .dbus_wdata   (dbus_wdata),
      .dbus_data_ok (dbus_data_ok),
      .dbus_rdata   (dbus_rdata)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int dv_cnt = 0;
   int resp_cnt = 0;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) if (dbus_valid) dv_cnt <= dv_cnt + 1;
   always @(posedge clk) if (resp_valid) resp_cnt <= resp_cnt + 1;

   typedef struct {
      logic [63:0] rdata;
      logic        err;
   } exp_t;
   exp_t sb[$];

   int n_vec = 0;
   int n_err = 0;

   // Expected bus beats for the next access.
   int          nbt = 0;
   logic [63:0] bt_addr[2];
   logic [7:0]  bt_strb[2];
   logic [63:0] bt_wd[2];
   logic [63:0] bt_rd[2];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_beat(input int i, input logic [63:0] a, input logic [7:0] s,
                           input logic [63:0] w, input logic [63:0] r);
      bt_addr[i] = a;
      bt_strb[i] = s;
      bt_wd[i]   = w;
      bt_rd[i]   = r;
   endtask

   // Issue one access, play the bus for nbt beats with dly wait cycles each, check the response.
   task automatic run_access(input logic [63:0] addr, input logic [63:0] wd, input logic [3:0] mode,
                             input logic [63:0] exp_rd, input logic exp_err, input int dly);
      int   c0, dv0, waited;
      exp_t e;
      check_eq("req_ready_idle", 64'(req_ready), 64'd1);
      req_valid = 1'b1;
      req_addr  = addr;
      req_wdata = wd;
      req_mode  = mode;
      e.rdata = exp_rd;
      e.err   = exp_err;
      sb.push_back(e);
      c0  = cyc;
      dv0 = dv_cnt;
      step();
      req_valid = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_mode  = '0;
      for (int b = 0; b < nbt; b++) begin
         for (int w = 0; w <= dly; w++) begin
            check_eq($sformatf("dbus_valid_b%0d", b), 64'(dbus_valid), 64'd1);
            check_eq($sformatf("dbus_addr_b%0d", b), dbus_addr, bt_addr[b]);
            check_eq($sformatf("dbus_strobe_b%0d", b), 64'(dbus_strobe), 64'(bt_strb[b]));
            check_eq($sformatf("dbus_wdata_b%0d", b), dbus_wdata, bt_wd[b]);
            check_eq("dbus_size", 64'(dbus_size), 64'd3);
            check_eq("req_ready_busy", 64'(req_ready), 64'd0);
            if (w == dly) begin
               dbus_data_ok = 1'b1;
               dbus_rdata   = bt_rd[b];
            end
            step();
            dbus_data_ok = 1'b0;
            dbus_rdata   = '0;
         end
      end
      waited = 0;
      while (!resp_valid && waited < 8) begin
         step();
         waited++;
      end
      check_eq("resp_valid", 64'(resp_valid), 64'd1);
      if (resp_valid) begin
         if (sb.size() == 0) begin
            check_eq("sb_nonempty", 64'd0, 64'(sb.size() + 1));
         end else begin
            e = sb.pop_front();
            check_eq("resp_rdata", resp_rdata, e.rdata);
            check_eq("resp_err", 64'(resp_err), 64'(e.err));
         end
      end
      check_eq("latency", 64'(cyc - c0), 64'(nbt * (dly + 1) + 1));
      check_eq("dbus_valid_cycles", 64'(dv_cnt - dv0), 64'(nbt * (dly + 1)));
      step();
      check_eq("resp_pulse_end", 64'(resp_valid), 64'd0);
      check_eq("req_ready_back", 64'(req_ready), 64'd1);
   endtask

   localparam logic [63:0] Rd0 = 64'h8877665544332211;
   localparam logic [63:0] Rd1 = 64'h00FFEEDDCCBBAA99;

   initial begin
      int rc0;
      // Reset state.
      #1;
      check_eq("rst_req_ready", 64'(req_ready), 64'd0);
      check_eq("rst_dbus_valid", 64'(dbus_valid), 64'd0);
      check_eq("rst_resp_valid", 64'(resp_valid), 64'd0);
      check_eq("rst_resp_rdata", resp_rdata, 64'd0);
      step();
      step();
      reset_n = 1'b1;
      step();
      check_eq("post_rst_ready", 64'(req_ready), 64'd1);

      // Aligned single-beat loads.
      nbt = 1;
      set_beat(0, 64'h1000, 8'h00, 64'h0, Rd0);
      run_access(64'h1007, 64'h0, 4'h0, 64'hFFFFFFFFFFFFFF88, 1'b0, 0);  // lb
      run_access(64'h1003, 64'h0, 4'h4, 64'h44, 1'b0, 0);               // lbu
      run_access(64'h1006, 64'h0, 4'h5, 64'h8877, 1'b0, 0);             // lhu
      run_access(64'h1006, 64'h0, 4'h1, 64'hFFFFFFFFFFFF8877, 1'b0, 1); // lh
      run_access(64'h1004, 64'h0, 4'h2, 64'hFFFFFFFF88776655, 1'b0, 0); // lw
      run_access(64'h1004, 64'h0, 4'h6, 64'h88776655, 1'b0, 2);         // lwu
      run_access(64'h1000, 64'h0, 4'h3, Rd0, 1'b0, 0);                  // ld
      run_access(64'h1000, 64'h0, 4'h2, 64'h44332211, 1'b0, 0);         // lw positive

      // Aligned single-beat stores.
      set_beat(0, 64'h1000, 8'hC0, 64'hBEEF000000000000, Rd0);
      run_access(64'h1006, 64'hBEEF, 4'h9, 64'h0, 1'b0, 0);             // sh
      set_beat(0, 64'h1000, 8'h02, 64'h000000000000A500, Rd0);
      run_access(64'h1001, 64'hA5, 4'h8, 64'h0, 1'b0, 2);               // sb
      set_beat(0, 64'h2000, 8'hFF, 64'h0123456789ABCDEF, Rd0);
      run_access(64'h2000, 64'h0123456789ABCDEF, 4'hB, 64'h0, 1'b0, 0); // sd

      // Illegal modes: no bus beat, error response one cycle after acceptance.
      nbt = 0;
      run_access(64'h1000, 64'h0, 4'hD, 64'h0, 1'b1, 0);                // store with unsigned
      run_access(64'h1000, 64'h0, 4'h7, 64'h0, 1'b1, 0);                // unsigned doubleword

`ifdef MEM_MISALIGN_SPLIT_EN
      nbt = 2;
      set_beat(0, 64'h1000, 8'h00, 64'h0, Rd0);
      set_beat(1, 64'h1008, 8'h00, 64'h0, Rd1);
      run_access(64'h1004, 64'h0, 4'h3, 64'hCCBBAA9988776655, 1'b0, 0); // ld split
      set_beat(0, 64'h1008, 8'hC0, 64'hBEEF000000000000, Rd0);
      set_beat(1, 64'h1010, 8'h03, 64'h000000000000DEAD, Rd1);
      run_access(64'h100E, 64'hDEADBEEF, 4'hA, 64'h0, 1'b0, 3);         // sw split, slow bus
      set_beat(0, 64'hFFFFFFFFFFFFFFF8, 8'h00, 64'h0, Rd0);
      set_beat(1, 64'h0, 8'h00, 64'h0, Rd1);
      run_access(64'hFFFFFFFFFFFFFFFC, 64'h0, 4'h3, 64'hCCBBAA9988776655, 1'b0, 0); // wrap
      nbt = 1;
      set_beat(0, 64'h1000, 8'h00, 64'h0, Rd0);
      run_access(64'h1001, 64'h0, 4'h1, 64'h3322, 1'b0, 0);             // misaligned, no cross
`else
      run_access(64'h1004, 64'h0, 4'h3, 64'h0, 1'b1, 0);
      run_access(64'h100E, 64'hDEADBEEF, 4'hA, 64'h0, 1'b1, 0);
      run_access(64'hFFFFFFFFFFFFFFFC, 64'h0, 4'h3, 64'h0, 1'b1, 0);
      run_access(64'h1001, 64'h0, 4'h1, 64'h0, 1'b1, 0);
`endif

      // Asynchronous reset in the middle of a beat discards the access.
      req_valid = 1'b1;
      req_addr  = 64'h1007;
      req_mode  = 4'h0;
      step();
      req_valid = 1'b0;
      check_eq("abort_beat_active", 64'(dbus_valid), 64'd1);
      rc0 = resp_cnt;
      #3;
      reset_n = 1'b0;
      #1;
      check_eq("abort_dbus_valid", 64'(dbus_valid), 64'd0);
      check_eq("abort_req_ready", 64'(req_ready), 64'd0);
      check_eq("abort_resp_valid", 64'(resp_valid), 64'd0);
      step();
      step();
      reset_n = 1'b1;
      step();
      check_eq("abort_ready_after", 64'(req_ready), 64'd1);
      step();
      step();
      step();
      check_eq("abort_no_resp", 64'(resp_cnt - rc0), 64'd0);
      check_eq("abort_idle_bus", 64'(dbus_valid), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Sequential load/store unit between the memory stage and the data bus.
- Accepts one access per handshake.
- Aligns address, strobe and write data to a parametrised bus width.
- Waits for the bus, then extracts and sign/zero-extends load data.
- Optionally splits a misaligned access that crosses a bus-word boundary into two bus beats.
- Supersedes the earlier combinational helper, which handled only 4-byte alignment and had no load path or handshake.

Parameters:
XLEN, 64, register/data width in bits (32 or 64).
BUS_BYTES, 8, data-bus width in bytes (4 or 8, power of two).
AW, 64, address width in bits.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous, active-low reset
req_valid  in  1  access request
req_ready  out  1  unit can accept (high only in IDLE)
req_addr  in  AW  byte address
req_wdata  in  XLEN  store data, right-justified
req_mode  in  4  bit3 store, bit2 unsigned (loads only), bits1:0 log2 size (B/H/W/D)
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  XLEN  extended load result; 0 for stores
resp_err  out  1  illegal mode, or misaligned access with split disabled; qualified by resp_valid
dbus_valid  out  1  bus request, held until dbus_data_ok
dbus_addr  out  AW  req address with low log2(BUS_BYTES) bits cleared
dbus_size  out  3  always log2(BUS_BYTES)
dbus_strobe  out  BUS_BYTES  byte write mask; all 0 for loads
dbus_wdata  out  8*BUS_BYTES  store data shifted to byte lane
dbus_data_ok  in  1  bus beat complete
dbus_rdata  in  8*BUS_BYTES  bus read data

Behaviour:
- Reset: all outputs 0, state IDLE; req_ready is 1 after release. Reset is asynchronous: asserting reset_n mid-access drops dbus_valid immediately and discards the access; no resp_valid is issued for it.
- States: IDLE, BEAT0, BEAT1, RESP.
- IDLE:
  - On req_valid && req_ready, latch addr, wdata and mode, and compute off = addr mod BUS_BYTES and n = 2^mode[1:0].
  - Illegal (go to RESP with err=1, no bus beat):
    - mode[1:0]=3 with XLEN=32;
    - 8-byte access with BUS_BYTES=4;
    - store with mode[2]=1;
    - unsigned doubleword load.
  - Otherwise go to BEAT0.
- BEAT0:
  - dbus_valid=1, dbus_addr = aligned addr.
  - Strobe covers bytes off..min(off+n, BUS_BYTES)-1; wdata bytes shifted left by off lanes.
  - dbus_valid and all dbus_* outputs stay stable until dbus_data_ok.
  - On dbus_data_ok, capture the low-part bytes of dbus_rdata.
  - Next state is BEAT1 if off+n > BUS_BYTES, else RESP.
- BEAT1:
  - dbus_addr = aligned addr + BUS_BYTES.
  - Strobe covers bytes 0..off+n-BUS_BYTES-1; carries the remaining upper wdata bytes.
  - On dbus_data_ok, capture and merge the high-part bytes, then go to RESP.
- dbus_valid falls in the cycle after dbus_data_ok. dbus_data_ok is ignored outside BEAT0/BEAT1.
- RESP:
  - resp_valid=1 for exactly one cycle, with resp_rdata = merged bytes, sign-extended unless mode[2].
  - Then go to IDLE; req_ready returns high the same cycle resp_valid drops.
- Latency: acceptance cycle t; dbus_valid from t+1; data_ok at cycle k gives resp_valid at k+1. A zero-wait bus gives resp at t+2 for one beat, t+3 for two beats.
- Address arithmetic wraps modulo 2^AW; a split at the top of the address space addresses 0 in BEAT1.
- req_valid while not ready is not accepted; the requester holds it.

Optional Feature:
MEM_MISALIGN_SPLIT_EN.
- Defined: behaviour as above, with two-beat split for boundary-crossing accesses.
- Undefined: any access with addr mod n != 0 goes IDLE to RESP with resp_err=1; no bus beat is issued and BEAT1 logic is absent.
- Accesses that are naturally aligned behave identically in both builds.

Test Plan:
- lb 0x1007, dbus_rdata 0x8877665544332211 -> dbus_addr 0x1000, strobe 0x00, resp_rdata 0xFFFFFFFFFFFFFF88, resp at acceptance+2.
- lbu 0x1003, same data -> resp_rdata 0x44; lhu 0x1006 -> 0x8877.
- sh 0x1006, wdata 0xBEEF -> strobe 0xC0, dbus_wdata 0xBEEF000000000000, resp_rdata 0, err 0.
- MEM_MISALIGN_SPLIT_EN defined, ld 0x1004; beat0 0x1000 returns 0x8877665544332211, beat1 0x1008 returns 0x00FFEEDDCCBBAA99 -> resp_rdata 0xCCBBAA9988776655. Undefined: resp_err=1, dbus_valid never asserted.
- sw 0x100E with split -> beat0 strobe 0xC0, beat1 strobe 0x03; data_ok delayed 3 cycles per beat -> bus outputs stable throughout, single resp_valid pulse.
- reset_n low during BEAT0 -> dbus_valid 0 without waiting for a clock edge, no resp_valid; after release req_ready=1.
